// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter: header tag default, byte
// width, FSM state encoding and the record-length helper.
package fifo_pkg;

  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;
  localparam int         BYTE_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_e;

  // Number of payload bytes carried by one record of data_w bits.
  function automatic int bytes_per_record(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: starting just after the last granted
// index and wrapping modulo N_REQ, the first eligible requester wins.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [1:0]       last,
  output logic             grant_valid,
  output logic [1:0]       grant_idx
);

  int   cand_s;
  logic hit_s;

  // Walk last+1, last+2, ... and keep the first eligible candidate.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand_s      = 0;
    hit_s       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s      = (int'(last) + k >= N_REQ) ? int'(last) + k - N_REQ : int'(last) + k;
      hit_s       = ~grant_valid & (|(eligible & (N_REQ'(1'b1) << cand_s)));
      grant_idx   = hit_s ? 2'(cand_s) : grant_idx;
      grant_valid = grant_valid | hit_s;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the byte-wide serial-out FIFO between N_REQ record producers.
// A granted record is latched, then written as one tag header byte followed
// by the payload MSB-first, stalling on fifo_full. The served requester gets
// a one-cycle done pulse and is masked for the following IDLE cycle so a late
// req drop does not cause a second grant.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int         N_REQ      = 3,
  parameter int         DATA_W     = 48,
  parameter logic [3:0] HEADER_TAG = HEADER_TAG_DEFAULT,
  parameter int         CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [7:0]              fifo_din,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic [CNT_W-1:0]        record_count
);

  localparam int BYTES  = bytes_per_record(DATA_W);
  localparam int BCNT_W = $clog2(BYTES + 1);

  wr_state_e          state_r;
  logic [1:0]         last_r;
  logic [N_REQ-1:0]   mask_r;
  logic [DATA_W-1:0]  shift_r;
  logic [BCNT_W-1:0]  byte_cnt_r;
  logic [1:0]         grant_id_r;
  logic [N_REQ-1:0]   done_r;
  logic               busy_r;
  logic [CNT_W-1:0]   count_r;

  logic [N_REQ-1:0]   eligible_s;
  logic               grant_valid_s;
  logic [1:0]         grant_idx_s;
  logic               wr_en_s;
  logic [7:0]         din_s;

  assign eligible_s = req & ~mask_r;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .eligible    (eligible_s),
    .last        (last_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Byte presented to the FIFO; only the HEADER and PAYLOAD states write.
  always_comb begin
    wr_en_s = 1'b0;
    din_s   = 8'h00;
    case (state_r)
      ST_HEADER: begin
        din_s   = {HEADER_TAG, 2'b00, grant_id_r};
        wr_en_s = ~fifo_full;
      end
      ST_PAYLOAD: begin
        din_s   = shift_r[DATA_W-1 -: BYTE_W];
        wr_en_s = ~fifo_full;
      end
      default: begin
        din_s   = 8'h00;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Record FSM: grant, header, payload shift-out, done pulse and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      last_r     <= 2'(N_REQ - 1);
      mask_r     <= '0;
      shift_r    <= '0;
      byte_cnt_r <= '0;
      grant_id_r <= 2'd0;
      done_r     <= '0;
      busy_r     <= 1'b0;
      count_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= '0;
          mask_r <= '0;
          if (enable && grant_valid_s) begin
            grant_id_r <= grant_idx_s;
            last_r     <= grant_idx_s;
            shift_r    <= data[grant_idx_s*DATA_W +: DATA_W];
            byte_cnt_r <= '0;
            busy_r     <= 1'b1;
            state_r    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (wr_en_s) begin
            state_r <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (wr_en_s) begin
            shift_r    <= {shift_r[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
            if (byte_cnt_r == BCNT_W'(BYTES - 1)) begin
              done_r  <= N_REQ'(1'b1) << grant_id_r;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_r  <= '0;
          mask_r  <= N_REQ'(1'b1) << grant_id_r;
          count_r <= count_r + CNT_W'(1);
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_wr_en   = wr_en_s;
  assign fifo_din     = din_s;
  assign done         = done_r;
  assign busy         = busy_r;
  assign grant_id     = grant_id_r;
  assign record_count = count_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: table-driven single records,
// hand-written multi-cycle sequences, and a randomized run checked against a
// transaction-level round-robin reference model.
module tb_fifo_write_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 48;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [7:0]              fifo_din;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic [1:0]              grant_id;
  logic [CNT_W-1:0]        record_count;

  int checks   = 0;
  int failures = 0;

  fifo_write_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_W     (DATA_W),
    .HEADER_TAG (4'hA),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .data         (data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .done         (done),
    .busy         (busy),
    .grant_id     (grant_id),
    .record_count (record_count)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  req_v;
    logic [47:0] payload;
    logic [55:0] exp_stream;
    logic [2:0]  exp_done;
  } vec_t;

  vec_t vecs [3];

  // scratch for sequences
  logic [55:0] stream;
  int          nbytes, hdr_k, done_k;
  logic [2:0]  done_v;
  logic        any_bad;
  logic [7:0]  hv [4];
  int          hks [4];
  int          nh, wcnt;
  logic        raise0;
  // random-phase reference model state
  int          m_last, widx, cur_id, m_count;
  logic        done_due, finished;
  logic [55:0] exp_rec;
  logic [2:0]  exp_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // fill all slots with random data, then place payload p into requester slot(s) of r
  task automatic load(input logic [2:0] r, input logic [47:0] p);
    for (int i = 0; i < N_REQ; i++) begin
      data[i*DATA_W +: DATA_W] = {16'($urandom), $urandom};
      if (r[i]) data[i*DATA_W +: DATA_W] = p;
    end
  endtask

  // reference round-robin choice: first set bit after last, modulo N_REQ
  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (last + k) % N_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    req   = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_rec(input int max_cyc, input int stall_at, input int stall_len,
                         input logic [7:0] stall_byte, input int en_off_at,
                         output logic [55:0] s, output int nb, output int hk,
                         output int dk, output logic [2:0] dv);
    s = '0; nb = 0; hk = 0; dk = 0; dv = '0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      fifo_full = (k >= stall_at) && (k < stall_at + stall_len);
      if (k == en_off_at) enable = 1'b0;
      #1;
      if (fifo_full) begin
        check("stall_no_write", fifo_wr_en, 1'b0);
        check("stall_hold_byte", fifo_din, stall_byte);
      end else if (fifo_wr_en) begin
        s = {s[47:0], fifo_din};
        nb++;
        if (nb == 1) hk = k;
      end
      if (done !== 3'b000) begin
        dv = done;
        dk = k;
        fifo_full = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL record_timeout: no done within %0d cycles", max_cyc);
    fifo_full = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b001, 48'h0123_4567_89AB, 56'hA0_0123_4567_89AB, 3'b001};
    vecs[1] = '{3'b100, 48'hFEDC_BA98_7654, 56'hA2_FEDC_BA98_7654, 3'b100};
    vecs[2] = '{3'b010, 48'h5A5A_00FF_1234, 56'hA1_5A5A_00FF_1234, 3'b010};

    rst_n = 1'b0; enable = 1'b1; req = '0; data = '0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_outputs", {fifo_wr_en, fifo_din, done, busy, grant_id, record_count}, 64'd0);

    // table-driven single records, no backpressure
    for (int i = 0; i < 3; i++) begin
      req = vecs[i].req_v;
      load(vecs[i].req_v, vecs[i].payload);
      run_rec(40, 0, 0, 8'h00, 0, stream, nbytes, hdr_k, done_k, done_v);
      check($sformatf("vec%0d_stream", i), {8'(nbytes), stream}, {8'd7, vecs[i].exp_stream});
      check($sformatf("vec%0d_latency", i), hdr_k * 100 + done_k, 64'd108);
      check($sformatf("vec%0d_done", i), done_v, vecs[i].exp_done);
      req = '0;
      @(negedge clk); #1;
      check($sformatf("vec%0d_count_idle", i), {busy, record_count}, {1'b0, 16'(i + 1)});
    end

    // backpressure: 5 stalled cycles on payload byte 3
    req = 3'b001;
    load(3'b001, 48'h0123_4567_89AB);
    run_rec(60, 4, 5, 8'h45, 0, stream, nbytes, hdr_k, done_k, done_v);
    check("bp_stream", {8'(nbytes), stream}, {8'd7, 56'hA0_0123_4567_89AB});
    check("bp_done_cycle", done_k, 64'd13);
    req = '0;
    @(negedge clk);

    // late deassert: requester 1 keeps req one cycle past done
    req = 3'b010;
    load(3'b010, 48'hC0FF_EE12_3456);
    run_rec(40, 0, 0, 8'h00, 0, stream, nbytes, hdr_k, done_k, done_v);
    check("late_stream", {8'(nbytes), stream}, {8'd7, 56'hA1_C0FF_EE12_3456});
    any_bad = 1'b0;
    @(negedge clk); #1;
    any_bad = any_bad | fifo_wr_en | busy;
    req = '0;
    repeat (5) begin
      @(negedge clk); #1;
      any_bad = any_bad | fifo_wr_en | busy;
    end
    check("late_no_regrant", any_bad, 1'b0);

    // reset in the middle of a record
    req = 3'b001;
    load(3'b001, 48'h1111_2222_3333);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_outputs", {fifo_wr_en, fifo_din, done, busy, grant_id, record_count}, 64'd0);
    any_bad = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      any_bad = any_bad | (|done) | fifo_wr_en;
    end
    check("midreset_no_done", any_bad, 1'b0);
    req = 3'b111;
    load(3'b000, 48'h0);
    run_rec(40, 0, 0, 8'h00, 0, stream, nbytes, hdr_k, done_k, done_v);
    check("midreset_first_grant", stream[55:48], 8'hA0);
    pulse_reset();

    // contention: all three held, each dropped on its done, requester 0 re-raised
    req = 3'b111;
    load(3'b000, 48'h0);
    raise0 = 1'b0; nh = 0; wcnt = 0;
    for (int j = 0; j < 4; j++) begin hv[j] = 8'h00; hks[j] = 0; end
    for (int k = 1; k <= 60 && nh < 4; k++) begin
      @(negedge clk); #1;
      if (raise0) begin req[0] = 1'b1; raise0 = 1'b0; end
      if (fifo_wr_en) begin
        if (wcnt % 7 == 0) begin hv[nh] = fifo_din; hks[nh] = k; nh++; end
        wcnt++;
      end
      if (done != 3'b000) begin
        if (done[0]) raise0 = 1'b1;
        req = req & ~done;
      end
    end
    check("rr_hdr0", {hv[0], 8'(hks[0])}, {8'hA0, 8'd1});
    check("rr_hdr1", {hv[1], 8'(hks[1])}, {8'hA1, 8'd10});
    check("rr_hdr2", {hv[2], 8'(hks[2])}, {8'hA2, 8'd19});
    check("rr_hdr3", {hv[3], 8'(hks[3])}, {8'hA0, 8'd28});
    pulse_reset();

    // enable gating
    enable = 1'b0;
    req = 3'b010;
    load(3'b010, 48'hABCD_EF01_2345);
    any_bad = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      any_bad = any_bad | fifo_wr_en | busy;
    end
    check("en_off_no_grant", any_bad, 1'b0);
    enable = 1'b1;
    run_rec(40, 0, 0, 8'h00, 3, stream, nbytes, hdr_k, done_k, done_v);
    check("en_drop_completes", {8'(nbytes), stream}, {8'd7, 56'hA1_ABCD_EF01_2345});
    check("en_drop_done", done_v, 3'b010);
    req = 3'b101;
    any_bad = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      any_bad = any_bad | fifo_wr_en | busy;
    end
    check("en_drop_no_more_grant", any_bad, 1'b0);
    enable = 1'b1;
    run_rec(40, 0, 0, 8'h00, 0, stream, nbytes, hdr_k, done_k, done_v);
    check("en_resume_rr", stream[55:48], 8'hA2);
    pulse_reset();

    // randomized traffic against the reference model
    enable = 1'b1;
    m_last = N_REQ - 1; widx = 0; cur_id = 0; m_count = 0;
    done_due = 1'b0; finished = 1'b0; exp_rec = '0;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      @(negedge clk);
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      exp_done = done_due ? (3'b001 << cur_id) : 3'b000;
      check("rand_done", done, exp_done);
      done_due = 1'b0;
      if (fifo_full) check("rand_full_no_write", fifo_wr_en, 1'b0);
      if (fifo_wr_en) begin
        if (widx == 0) begin
          cur_id = rr_pick(req, m_last);
          if (cur_id < 0) begin
            check("rand_unexpected_write", fifo_wr_en, 1'b0);
            cur_id = 0;
          end
          m_last  = cur_id;
          exp_rec = {4'hA, 2'b00, 2'(cur_id), data[cur_id*DATA_W +: DATA_W]};
        end
        check("rand_byte", fifo_din, exp_rec[55-8*widx -: 8]);
        widx++;
        if (widx == 7) begin widx = 0; done_due = 1'b1; end
      end
      if (exp_done != 3'b000) begin
        m_count++;
        req = req & ~exp_done;
        if (cyc < 4000) begin
          for (int j = 0; j < N_REQ; j++) begin
            if (!req[j] && j != cur_id && $urandom_range(0, 1) == 1) begin
              data[j*DATA_W +: DATA_W] = {16'($urandom), $urandom};
              req[j] = 1'b1;
            end
          end
        end
      end else if (req == 3'b000 && widx == 0 && cyc < 4000 && $urandom_range(0, 3) == 0) begin
        for (int j = 0; j < N_REQ; j++) begin
          if ($urandom_range(0, 1) == 1) begin
            data[j*DATA_W +: DATA_W] = {16'($urandom), $urandom};
            req[j] = 1'b1;
          end
        end
      end
      if (cyc >= 4000 && req == 3'b000 && widx == 0 && !done_due) finished = 1'b1;
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL rand_drain_timeout: traffic did not drain, records seen %0d", m_count);
    end
    fifo_full = 1'b0;
    @(negedge clk); #1;
    check("rand_record_count", record_count, 16'(m_count));
    check("rand_final_idle", {busy, fifo_wr_en}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
